uart_matrix_loader: RTL and testbench
=====================================

Name: uart_matrix_loader

Overview:
Parametrised successor to the hand-wired UART-to-4-RAM load path. It assembles received UART bytes into words and fills N_BANKS internal banks of DEPTH words each, bank by bank. It then streams full rows (one word from every bank at the same address) to a downstream consumer such as the systolic multiplier, using a valid/ready handshake, with optional looping. It sits between uart_rx (byte + valid pulse) and the compute array.

Parameters:
N_BANKS, 4, number of banks; also the number of words per output row
DEPTH, 10, words per bank
BYTE_W, 8, width of an input byte
BYTES_PER_WORD, 4, bytes packed into one word
DATA_W, BYTE_W*BYTES_PER_WORD, word width (derived; not overridden)
ADDR_W, $clog2(DEPTH), bank address width (derived)

Ports:
i_clk  in  1  single clock
i_reset  in  1  asynchronous, active-high reset
i_byte  in  BYTE_W  received byte
i_byte_valid  in  1  one-cycle pulse qualifying i_byte
i_start  in  1  pulse; begin streaming (honoured only in READY)
i_loop  in  1  1 = wrap to row 0 after the last row; 0 = stop
i_clear  in  1  synchronous pulse; discard contents and return to LOAD
o_row_data  out  N_BANKS*DATA_W  bank0 word in MSBs, bank N_BANKS-1 word in LSBs
o_row_valid  out  1  o_row_data is valid
i_row_ready  in  1  consumer accepts the row
o_load_done  out  1  high in READY and STREAM
o_overflow  out  1  sticky; a byte arrived outside LOAD
o_checksum  out  16  see Optional Feature

Behaviour:
- Reset (asynchronous, any state):
  - State goes to LOAD; byte, word, bank and row counters clear.
  - o_row_data=0, o_row_valid=0, o_load_done=0, o_overflow=0, o_checksum=0.
  - Bank contents are not cleared.
- States: LOAD -> READY -> STREAM -> (READY | STREAM).
- LOAD:
  - Each i_byte_valid shifts the byte into the word assembler, little-endian: the first byte lands in bits [BYTE_W-1:0].
  - On the edge that samples byte BYTES_PER_WORD, the word is written to bank[bank_idx][addr] in the same cycle. The byte counter then resets.
  - addr increments from 0 to DEPTH-1, then wraps to 0 and bank_idx increments.
  - Writing bank N_BANKS-1, address DEPTH-1 moves the state to READY on that same edge.
  - i_start is ignored in LOAD.
- READY:
  - o_load_done=1.
  - On i_start, go to STREAM with row pointer 0. o_row_data is registered, so o_row_valid rises the cycle after i_start.
- STREAM:
  - o_row_data and o_row_valid are held stable while i_row_ready is low.
  - On valid&&ready, advance the row pointer and register the next row in the same cycle. This gives back-to-back rows at full rate.
  - After row DEPTH-1 is accepted:
    - i_loop=1: present row 0 next cycle.
    - i_loop=0: o_row_valid=0 next cycle and return to READY. Contents are kept, so i_start replays.
  - i_loop is sampled at the acceptance of the last row.
- Bytes outside LOAD: i_byte_valid in READY or STREAM drops the byte, sets o_overflow (cleared only by reset or i_clear), and leaves banks untouched.
- i_clear (any state):
  - Next state is LOAD; counters clear and o_row_valid=0.
  - o_overflow and o_checksum clear.
- Priority: i_clear overrides i_byte_valid and i_start in the same cycle. i_byte_valid and i_start together in LOAD: the byte is taken and the start ignored.
- Partial word: if i_clear or reset arrives mid-word, the partial word is discarded.

Optional Feature:
UART_LOADER_CHECKSUM_EN
- Defined: o_checksum is a 16-bit modulo-2^16 sum of every byte accepted in LOAD. It updates one cycle after each byte and clears on reset or i_clear.
- Undefined: no adder is built and o_checksum is tied to 0.

Decomposition:
- Package uart_loader_pkg:
  - state enum (LOAD, READY, STREAM)
  - CHECKSUM_W=16
  - default parameter constants
- Sub-module loader_bank: DEPTH x DATA_W register array, one synchronous write port, combinational read. It is instantiated N_BANKS times in a generate loop. The top level owns the FSM, the assembler and the row register.

Test Plan:
Configuration for all scenarios: N_BANKS=4, DEPTH=2, BYTES_PER_WORD=4, i.e. 32 bytes per full load.
1. Bytes 0x00..0x1F, then i_start -> o_load_done rises on the 32nd byte. Row0 = 0x03020100_0B0A0908_13121110_1B1A1918; row1 = 0x07060504_0F0E0D0C_17161514_1F1E1D1C.
2. i_row_ready low for 3 cycles with row0 valid -> o_row_data and o_row_valid remain unchanged. The first ready cycle accepts row0 and row1 appears on the next cycle.
3. i_loop=0 -> o_row_valid=0 after row1 is accepted and the state is READY; a second i_start replays row0. Repeat with i_loop=1 -> row0 follows row1 without a gap.
4. Byte 0xAA during STREAM -> o_overflow=1 and streamed rows are unchanged; i_clear -> o_overflow=0, o_load_done=0.
5. Assert i_reset asynchronously after 5 bytes -> all outputs 0 immediately. Reload 0x00..0x1F -> result matches scenario 1.
6. With UART_LOADER_CHECKSUM_EN, bytes 0x00..0x1F -> o_checksum=0x01F0. Without the macro -> o_checksum=0.

Source files
------------

// File: rtl/uart_loader_pkg.sv
// Shared types and default constants for the UART matrix loader.
package uart_loader_pkg;

    localparam int unsigned CHECKSUM_W         = 16;
    localparam int unsigned DEF_N_BANKS        = 4;
    localparam int unsigned DEF_DEPTH          = 10;
    localparam int unsigned DEF_BYTE_W         = 8;
    localparam int unsigned DEF_BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        READY  = 2'd1,
        STREAM = 2'd2
    } loader_state_e;

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/loader_bank.sv
// One word bank: DEPTH x DATA_W registers, synchronous write, combinational read.
module loader_bank #(
    parameter int unsigned DEPTH  = 10,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents survive reset and clear; only loading overwrites them.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/uart_matrix_loader.sv
// Packs UART bytes into words, fills N_BANKS banks, then streams rows over valid/ready.
// Optional running byte checksum: define UART_LOADER_CHECKSUM_EN.
module uart_matrix_loader
    import uart_loader_pkg::*;
#(
    parameter int unsigned N_BANKS        = DEF_N_BANKS,
    parameter int unsigned DEPTH          = DEF_DEPTH,
    parameter int unsigned BYTE_W         = DEF_BYTE_W,
    parameter int unsigned BYTES_PER_WORD = DEF_BYTES_PER_WORD
) (
    input  logic                                     i_clk,
    input  logic                                     i_reset,
    input  logic [BYTE_W-1:0]                        i_byte,
    input  logic                                     i_byte_valid,
    input  logic                                     i_start,
    input  logic                                     i_loop,
    input  logic                                     i_clear,
    output logic [N_BANKS*BYTE_W*BYTES_PER_WORD-1:0] o_row_data,
    output logic                                     o_row_valid,
    input  logic                                     i_row_ready,
    output logic                                     o_load_done,
    output logic                                     o_overflow,
    output logic [CHECKSUM_W-1:0]                    o_checksum
);

    localparam int unsigned DATA_W = BYTE_W * BYTES_PER_WORD;
    localparam int unsigned PART_W = DATA_W - BYTE_W;
    localparam int unsigned ROW_W  = N_BANKS * DATA_W;
    localparam int unsigned ADDR_W = clog2_min1(DEPTH);
    localparam int unsigned BANK_W = clog2_min1(N_BANKS);
    localparam int unsigned BCNT_W = clog2_min1(BYTES_PER_WORD);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(N_BANKS - 1);
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_WORD - 1);

    loader_state_e     state_q, state_d;
    logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [PART_W-1:0] part_q, part_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [ADDR_W-1:0] row_ptr_q, row_ptr_d;
    logic [ROW_W-1:0]  row_data_q, row_data_d;
    logic              row_valid_q, row_valid_d;
    logic              load_done_q;
    logic              overflow_q, overflow_d;

    logic              byte_acc_c;
    logic              word_done_c;
    logic [DATA_W-1:0] wdata_c;
    logic [ADDR_W-1:0] rd_addr_c;
    logic [ROW_W-1:0]  row_c;
    logic [DATA_W-1:0] bank_rd [N_BANKS];

    assign byte_acc_c  = (state_q == LOAD) && i_byte_valid && !i_clear;
    assign word_done_c = byte_acc_c && (byte_cnt_q == LAST_BYTE);
    // Newest byte enters at the top, so the first byte ends up in the LSBs.
    assign wdata_c     = {i_byte, part_q};

    // Address of the row that will be registered next: row 0 on start or wrap.
    assign rd_addr_c = ((state_q == STREAM) && (row_ptr_q != LAST_ADDR))
                     ? row_ptr_q + ADDR_W'(1) : '0;

    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        loader_bank #(
            .DEPTH  (DEPTH),
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .i_clk   (i_clk),
            .i_we    (word_done_c && (bank_q == BANK_W'(b))),
            .i_waddr (addr_q),
            .i_wdata (wdata_c),
            .i_raddr (rd_addr_c),
            .o_rdata (bank_rd[b])
        );
        assign row_c[(N_BANKS-1-b)*DATA_W +: DATA_W] = bank_rd[b];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= LOAD;
            byte_cnt_q  <= '0;
            part_q      <= '0;
            addr_q      <= '0;
            bank_q      <= '0;
            row_ptr_q   <= '0;
            row_data_q  <= '0;
            row_valid_q <= 1'b0;
            load_done_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            part_q      <= part_d;
            addr_q      <= addr_d;
            bank_q      <= bank_d;
            row_ptr_q   <= row_ptr_d;
            row_data_q  <= row_data_d;
            row_valid_q <= row_valid_d;
            load_done_q <= (state_d != LOAD);
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        part_d      = part_q;
        addr_d      = addr_q;
        bank_d      = bank_q;
        row_ptr_d   = row_ptr_q;
        row_data_d  = row_data_q;
        row_valid_d = row_valid_q;
        overflow_d  = overflow_q;

        if (i_clear) begin
            state_d     = LOAD;
            byte_cnt_d  = '0;
            part_d      = '0;
            addr_d      = '0;
            bank_d      = '0;
            row_ptr_d   = '0;
            row_data_d  = '0;
            row_valid_d = 1'b0;
            overflow_d  = 1'b0;
        end else begin
            if (i_byte_valid && (state_q != LOAD)) begin
                overflow_d = 1'b1;
            end

            unique case (state_q)
                LOAD: begin
                    if (byte_acc_c) begin
                        if (word_done_c) begin
                            byte_cnt_d = '0;
                            if (addr_q == LAST_ADDR) begin
                                addr_d = '0;
                                if (bank_q == LAST_BANK) begin
                                    bank_d  = '0;
                                    state_d = READY;
                                end else begin
                                    bank_d = bank_q + BANK_W'(1);
                                end
                            end else begin
                                addr_d = addr_q + ADDR_W'(1);
                            end
                        end else begin
                            byte_cnt_d = byte_cnt_q + BCNT_W'(1);
                            part_d     = wdata_c[DATA_W-1:BYTE_W];
                        end
                    end
                end
                READY: begin
                    if (i_start) begin
                        state_d     = STREAM;
                        row_ptr_d   = '0;
                        row_data_d  = row_c;
                        row_valid_d = 1'b1;
                    end
                end
                STREAM: begin
                    if (row_valid_q && i_row_ready) begin
                        if (row_ptr_q == LAST_ADDR) begin
                            row_ptr_d = '0;
                            if (i_loop) begin
                                row_data_d = row_c;
                            end else begin
                                row_valid_d = 1'b0;
                                state_d     = READY;
                            end
                        end else begin
                            row_ptr_d  = row_ptr_q + ADDR_W'(1);
                            row_data_d = row_c;
                        end
                    end
                end
                default: state_d = LOAD;
            endcase
        end
    end

    assign o_row_data  = row_data_q;
    assign o_row_valid = row_valid_q;
    assign o_load_done = load_done_q;
    assign o_overflow  = overflow_q;

`ifdef UART_LOADER_CHECKSUM_EN
    logic [CHECKSUM_W-1:0] checksum_q;

    // Running modulo-2^16 sum of every byte taken into the banks.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            checksum_q <= '0;
        end else if (i_clear) begin
            checksum_q <= '0;
        end else if (byte_acc_c) begin
            checksum_q <= checksum_q + CHECKSUM_W'(i_byte);
        end
    end

    assign o_checksum = checksum_q;
`else
    assign o_checksum = '0;
`endif

endmodule

// File: tb/tb_uart_matrix_loader.sv
// Scoreboard bench for uart_matrix_loader with N_BANKS=4, DEPTH=2, 4-byte words.
module tb_uart_matrix_loader;

    localparam int unsigned NB    = 4;
    localparam int unsigned DP    = 2;
    localparam int unsigned BW    = 8;
    localparam int unsigned BPW   = 4;
    localparam int unsigned ROW_W = NB * BW * BPW;

    localparam logic [ROW_W-1:0] ROW0 = 128'h03020100_0B0A0908_13121110_1B1A1918;
    localparam logic [ROW_W-1:0] ROW1 = 128'h07060504_0F0E0D0C_17161514_1F1E1D1C;
`ifdef UART_LOADER_CHECKSUM_EN
    localparam logic [15:0] FULL_CKS = 16'h01F0;
    localparam logic [15:0] FIVE_CKS = 16'h000A;
`else
    localparam logic [15:0] FULL_CKS = 16'h0000;
    localparam logic [15:0] FIVE_CKS = 16'h0000;
`endif

    logic             i_clk;
    logic             i_reset;
    logic [BW-1:0]    i_byte;
    logic             i_byte_valid;
    logic             i_start;
    logic             i_loop;
    logic             i_clear;
    logic [ROW_W-1:0] o_row_data;
    logic             o_row_valid;
    logic             i_row_ready;
    logic             o_load_done;
    logic             o_overflow;
    logic [15:0]      o_checksum;

    logic [ROW_W-1:0] sb [$];
    int n_checks = 0;
    int n_fails  = 0;

    uart_matrix_loader #(
        .N_BANKS        (NB),
        .DEPTH          (DP),
        .BYTE_W         (BW),
        .BYTES_PER_WORD (BPW)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_byte       (i_byte),
        .i_byte_valid (i_byte_valid),
        .i_start      (i_start),
        .i_loop       (i_loop),
        .i_clear      (i_clear),
        .o_row_data   (o_row_data),
        .o_row_valid  (o_row_valid),
        .i_row_ready  (i_row_ready),
        .o_load_done  (o_load_done),
        .o_overflow   (o_overflow),
        .o_checksum   (o_checksum)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [BW-1:0] b);
        i_byte       = b;
        i_byte_valid = 1'b1;
        tick();
        i_byte_valid = 1'b0;
    endtask

    task automatic load_all();
        for (int i = 0; i < 32; i++) send_byte(BW'(i));
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // Accept n rows with ready held high, popping the scoreboard per accepted row.
    task automatic consume(input int n, output int gaps);
        logic [ROW_W-1:0] exp_row;
        gaps = 0;
        i_row_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            int w = 0;
            while (!o_row_valid && w < 20) begin
                tick();
                w++;
                gaps++;
            end
            n_checks++;
            if (!o_row_valid) begin
                n_fails++;
                $display("FAIL row_timeout: row %0d valid=%b required 1", k, o_row_valid);
                break;
            end
            if (sb.size() == 0) begin
                n_fails++;
                $display("FAIL sb_empty: row %0d got %h with nothing expected", k, o_row_data);
                break;
            end
            exp_row = sb.pop_front();
            if (o_row_data !== exp_row) begin
                n_fails++;
                $display("FAIL row_data: row %0d got %h required %h", k, o_row_data, exp_row);
            end
            tick();
        end
        i_row_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_byte = '0; i_byte_valid = 0; i_start = 0; i_loop = 0; i_clear = 0; i_row_ready = 0;
        tick(); tick();
        n_checks += 5;
        if (o_row_data !== '0) begin n_fails++; $display("FAIL reset_row_data: got %h required 0", o_row_data); end
        if (o_row_valid !== 1'b0) begin n_fails++; $display("FAIL reset_row_valid: got %b required 0", o_row_valid); end
        if (o_load_done !== 1'b0) begin n_fails++; $display("FAIL reset_load_done: got %b required 0", o_load_done); end
        if (o_overflow !== 1'b0) begin n_fails++; $display("FAIL reset_overflow: got %b required 0", o_overflow); end
        if (o_checksum !== 16'h0) begin n_fails++; $display("FAIL reset_checksum: got %h required 0", o_checksum); end
        i_reset = 1'b0;
        tick();
    endtask

    // Full load; a start pulse coinciding with a byte in LOAD must be ignored.
    task automatic test_load();
        for (int i = 0; i < 32; i++) begin
            if (i == 4) i_start = 1'b1;
            send_byte(BW'(i));
            i_start = 1'b0;
            if (i == 4) begin
                n_checks++;
                if (o_row_valid !== 1'b0) begin n_fails++; $display("FAIL start_in_load: valid got %b required 0", o_row_valid); end
            end
            if (i == 30) begin
                n_checks++;
                if (o_load_done !== 1'b0) begin n_fails++; $display("FAIL load_done_early: got %b required 0", o_load_done); end
            end
        end
        n_checks += 2;
        if (o_load_done !== 1'b1) begin n_fails++; $display("FAIL load_done: got %b required 1", o_load_done); end
        if (o_checksum !== FULL_CKS) begin n_fails++; $display("FAIL checksum_full: got %h required %h", o_checksum, FULL_CKS); end
    endtask

    task automatic test_backpressure();
        i_loop = 1'b0;
        sb.push_back(ROW0);
        sb.push_back(ROW1);
        pulse_start();
        for (int c = 0; c < 4; c++) begin
            n_checks += 2;
            if (o_row_valid !== 1'b1) begin n_fails++; $display("FAIL hold_valid: cycle %0d got %b required 1", c, o_row_valid); end
            if (o_row_data !== sb[0]) begin n_fails++; $display("FAIL hold_data: cycle %0d got %h required %h", c, o_row_data, sb[0]); end
            if (c < 3) tick();
        end
        i_row_ready = 1'b1;
        tick();
        void'(sb.pop_front());
        n_checks += 2;
        if (o_row_valid !== 1'b1) begin n_fails++; $display("FAIL next_valid: got %b required 1", o_row_valid); end
        if (o_row_data !== sb[0]) begin n_fails++; $display("FAIL next_row: got %h required %h", o_row_data, sb[0]); end
        tick();
        void'(sb.pop_front());
        i_row_ready = 1'b0;
        n_checks += 2;
        if (o_row_valid !== 1'b0) begin n_fails++; $display("FAIL stop_valid: got %b required 0", o_row_valid); end
        if (o_load_done !== 1'b1) begin n_fails++; $display("FAIL stop_ready: load_done got %b required 1", o_load_done); end
    endtask

    task automatic test_loop();
        int gaps;
        i_loop = 1'b0;
        sb.push_back(ROW0); sb.push_back(ROW1);
        pulse_start();
        consume(2, gaps);
        n_checks += 2;
        if (gaps !== 0) begin n_fails++; $display("FAIL replay_gaps: got %0d required 0", gaps); end
        if (o_row_valid !== 1'b0) begin n_fails++; $display("FAIL replay_end_valid: got %b required 0", o_row_valid); end

        i_loop = 1'b1;
        sb.push_back(ROW0); sb.push_back(ROW1); sb.push_back(ROW0); sb.push_back(ROW1);
        pulse_start();
        consume(4, gaps);
        n_checks += 2;
        if (gaps !== 0) begin n_fails++; $display("FAIL loop_gaps: got %0d required 0", gaps); end
        if (o_row_valid !== 1'b1) begin n_fails++; $display("FAIL loop_wrap_valid: got %b required 1", o_row_valid); end

        i_loop = 1'b0;
        sb.push_back(ROW0); sb.push_back(ROW1);
        consume(2, gaps);
        n_checks++;
        if (o_row_valid !== 1'b0) begin n_fails++; $display("FAIL loop_stop_valid: got %b required 0", o_row_valid); end
    endtask

    task automatic test_overflow_clear();
        int gaps;
        i_loop = 1'b0;
        sb.push_back(ROW0); sb.push_back(ROW1);
        pulse_start();
        send_byte(8'hAA);
        n_checks += 3;
        if (o_overflow !== 1'b1) begin n_fails++; $display("FAIL overflow_set: got %b required 1", o_overflow); end
        if (o_row_data !== sb[0]) begin n_fails++; $display("FAIL overflow_hold: got %h required %h", o_row_data, sb[0]); end
        if (o_checksum !== FULL_CKS) begin n_fails++; $display("FAIL overflow_cks: got %h required %h", o_checksum, FULL_CKS); end
        consume(2, gaps);
        send_byte(8'h55);
        n_checks++;
        if (o_overflow !== 1'b1) begin n_fails++; $display("FAIL overflow_sticky: got %b required 1", o_overflow); end
        i_clear = 1'b1;
        i_start = 1'b1;
        tick();
        i_clear = 1'b0;
        i_start = 1'b0;
        n_checks += 4;
        if (o_overflow !== 1'b0) begin n_fails++; $display("FAIL clear_overflow: got %b required 0", o_overflow); end
        if (o_load_done !== 1'b0) begin n_fails++; $display("FAIL clear_load_done: got %b required 0", o_load_done); end
        if (o_row_valid !== 1'b0) begin n_fails++; $display("FAIL clear_valid: got %b required 0", o_row_valid); end
        if (o_checksum !== 16'h0) begin n_fails++; $display("FAIL clear_checksum: got %h required 0", o_checksum); end
    endtask

    task automatic async_reset_pulse();
        #2;
        i_reset = 1'b1;
        #1;
        n_checks += 5;
        if (o_row_data !== '0) begin n_fails++; $display("FAIL arst_row_data: got %h required 0", o_row_data); end
        if (o_row_valid !== 1'b0) begin n_fails++; $display("FAIL arst_valid: got %b required 0", o_row_valid); end
        if (o_load_done !== 1'b0) begin n_fails++; $display("FAIL arst_load_done: got %b required 0", o_load_done); end
        if (o_overflow !== 1'b0) begin n_fails++; $display("FAIL arst_overflow: got %b required 0", o_overflow); end
        if (o_checksum !== 16'h0) begin n_fails++; $display("FAIL arst_checksum: got %h required 0", o_checksum); end
        #1;
        i_reset = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        int gaps;
        load_all();
        pulse_start();
        send_byte(8'hAA);
        async_reset_pulse();
        for (int i = 0; i < 5; i++) send_byte(BW'(i));
        n_checks++;
        if (o_checksum !== FIVE_CKS) begin n_fails++; $display("FAIL partial_cks: got %h required %h", o_checksum, FIVE_CKS); end
        async_reset_pulse();
        load_all();
        n_checks += 2;
        if (o_load_done !== 1'b1) begin n_fails++; $display("FAIL reload_done: got %b required 1", o_load_done); end
        if (o_checksum !== FULL_CKS) begin n_fails++; $display("FAIL reload_cks: got %h required %h", o_checksum, FULL_CKS); end
        i_loop = 1'b0;
        sb.push_back(ROW0); sb.push_back(ROW1);
        pulse_start();
        consume(2, gaps);
        n_checks++;
        if (sb.size() != 0) begin n_fails++; $display("FAIL sb_leftover: got %0d entries required 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_backpressure();
        test_loop();
        test_overflow_clear();
        load_all();
        test_loop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
